// File: rtl/booth_datapath.sv
// Radix-4 Booth multiplier datapath: operand registers, accumulator, shifter and
// product capture, sequenced by an external controller through add/sub/shift strobes.
module booth_datapath #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           Request,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  input  logic           add_s,
  input  logic           sub_s,
  input  logic           ashift_s,
  input  logic           Done,
  output logic [2:0]     Q,
  output logic [2*N-1:0] Product,
  output logic           Valid,
  output logic           Error
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [N+1:0]     a_q, a_d;
  logic [N-1:0]     qr_q, qr_d;
  logic             q1_q, q1_d;
  logic [N-1:0]     mreg_q, mreg_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             done_d_q;
  logic             done_rise_s;
  logic [N+1:0]     m_ext_s;

  assign done_rise_s = Done & ~done_d_q;
  assign m_ext_s     = {{2{mreg_q[N-1]}}, mreg_q};

  // Next-state: Request wins, then a Done edge in RUN, then a single control strobe.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    qr_d      = qr_q;
    q1_d      = q1_q;
    mreg_d    = mreg_q;
    product_d = product_q;
    valid_d   = valid_q;
    error_d   = error_q;
    if (Request) begin
      a_d     = {(N+2){1'b0}};
      qr_d    = Multiplier;
      q1_d    = 1'b0;
      mreg_d  = Multiplicand;
      valid_d = 1'b0;
      error_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (done_rise_s) begin
        // Capture reflects the pre-operation registers; any strobe this cycle is dropped.
        product_d = {a_q[N-1:0], qr_q};
        valid_d   = 1'b1;
        state_d   = HOLD;
      end else begin
        case ({add_s, sub_s, ashift_s})
          3'b000: a_d = a_q;
          3'b100: a_d = a_q + m_ext_s;
          3'b010: a_d = a_q - m_ext_s;
          3'b001: begin
            q1_d = qr_q[1];
            qr_d = {a_q[1:0], qr_q[N-1:2]};
            a_d  = {a_q[N+1], a_q[N+1], a_q[N+1:2]};
          end
          default: error_d = 1'b1;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      a_q       <= {(N+2){1'b0}};
      qr_q      <= {N{1'b0}};
      q1_q      <= 1'b0;
      mreg_q    <= {N{1'b0}};
      product_q <= {(2*N){1'b0}};
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      done_d_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      qr_q      <= qr_d;
      q1_q      <= q1_d;
      mreg_q    <= mreg_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      done_d_q  <= Done;
    end
  end

  assign Q       = {qr_q[1:0], q1_q};
  assign Product = product_q;
  assign Valid   = valid_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: a Booth-digit controller model drives the
// strobes and results are compared against plain signed multiplication.
module tb_booth_datapath;
  localparam int N = 8;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic          add;
  logic          sub;
  logic          sh;
  logic          done;
  logic [2:0]    q;
  logic [2*N-1:0] prod;
  logic          valid;
  logic          err;

  int checks   = 0;
  int failures = 0;

  booth_datapath #(.N(N)) dut (
    .Clock(clk), .nReset(rst_n), .Request(req),
    .Multiplicand(mcand), .Multiplier(mplier),
    .add_s(add), .sub_s(sub), .ashift_s(sh), .Done(done),
    .Q(q), .Product(prod), .Valid(valid), .Error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] triple(input logic [N-1:0] x, input int i);
    logic low;
    low = (i == 0) ? 1'b0 : x[2*i-1];
    return {x[2*i+1], x[2*i], low};
  endfunction

  function automatic int digit(input logic [N-1:0] x, input int i);
    logic [2:0] t;
    t = triple(x, i);
    return -2 * int'(t[2]) + int'(t[1]) + int'(t[0]);
  endfunction

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] x);
    logic signed [2*N-1:0] r;
    logic signed [N-1:0] ms;
    logic signed [N-1:0] xs;
    ms = m;
    xs = x;
    r  = ms * xs;
    return r;
  endfunction

  // Apply one cycle of inputs just after a falling edge; return at the next falling edge.
  task automatic cyc(input logic r, input logic a, input logic s, input logic h, input logic d);
    req = r; add = a; sub = s; sh = h; done = d;
    @(negedge clk);
  endtask

  task automatic load(input logic [N-1:0] m, input logic [N-1:0] x);
    mcand = m; mplier = x;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_steps(input logic [N-1:0] x, input string tag);
    int d;
    for (int i = 0; i < N/2; i++) begin
      checks++;
      if (q !== triple(x, i)) begin
        failures++;
        $display("FAIL %s_q step=%0d got=%b exp=%b", tag, i, q, triple(x, i));
      end
      d = digit(x, i);
      if (d > 0) for (int k = 0; k < d; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else       for (int k = 0; k < -d; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic finish_op(input logic [N-1:0] m, input logic [N-1:0] x, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (prod !== ref_mul(m, x) || valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_prod m=%0d x=%0d got=%h/%b exp=%h/1", tag, $signed(m), $signed(x),
               prod, valid, ref_mul(m, x));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_op(input logic [N-1:0] m, input logic [N-1:0] x, input string tag);
    load(m, x);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_clear got=%b exp=0", tag, valid);
    end
    run_steps(x, tag);
    finish_op(m, x, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 3'b000 || prod !== '0 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset q=%b prod=%h valid=%b err=%b exp=000/0/0/0", q, prod, valid, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q !== 3'b000 || prod !== '0 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release q=%b prod=%h valid=%b err=%b exp=000/0/0/0", q, prod, valid, err);
    end
  endtask

  task automatic test_directed();
    do_op(8'd3, 8'd5, "dir_3x5");
    checks++;
    if (prod !== 16'h000F) begin
      failures++;
      $display("FAIL dir_3x5_const got=%h exp=000F", prod);
    end
    do_op(8'hF9, 8'd6, "dir_m7x6");
    checks++;
    if (prod !== 16'hFFD6) begin
      failures++;
      $display("FAIL dir_m7x6_const got=%h exp=FFD6", prod);
    end
    do_op(8'h80, 8'h80, "dir_min_sq");
    checks++;
    if (prod !== 16'h4000) begin
      failures++;
      $display("FAIL dir_min_sq_const got=%h exp=4000", prod);
    end
  endtask

  task automatic test_q_shift();
    load(8'd9, 8'b0000_0110);
    checks++;
    if (q !== 3'b100) begin
      failures++;
      $display("FAIL qshift_load got=%b exp=100", q);
    end
    for (int i = 1; i <= 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (q !== triple(8'b0000_0110, i)) begin
        failures++;
        $display("FAIL qshift_%0d got=%b exp=%b", i, q, triple(8'b0000_0110, i));
      end
    end
  endtask

  task automatic test_error();
    logic [N-1:0] m;
    logic [N-1:0] x;
    m = 8'd37; x = 8'hB5;
    load(m, x);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || q !== triple(x, 0)) begin
      failures++;
      $display("FAIL error_set err=%b q=%b exp=1/%b", err, q, triple(x, 0));
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky got=%b exp=1", err);
    end
    run_steps(x, "err_run");
    finish_op(m, x, "err_run");
    load(8'd1, 8'd1);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL error_clear got=%b exp=0", err);
    end
  endtask

  task automatic test_reset_mid();
    load(8'd100, 8'd77);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || prod !== '0 || q !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid valid=%b prod=%h q=%b exp=0/0000/000", valid, prod, q);
    end
  endtask

  task automatic test_hold_idle();
    logic [2*N-1:0] held;
    do_op(8'd5, 8'd7, "hold");
    held = ref_mul(8'd5, 8'd7);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (prod !== held || valid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL hold_ignore prod=%h valid=%b err=%b exp=%h/1/0", prod, valid, err, held);
    end
    load(8'hC3, 8'h2D);
    checks++;
    if (valid !== 1'b0 || q !== triple(8'h2D, 0) || prod !== held) begin
      failures++;
      $display("FAIL hold_request valid=%b q=%b prod=%h exp=0/%b/%h", valid, q, prod,
               triple(8'h2D, 0), held);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || prod !== '0 || q !== 3'b000 || err !== 1'b0) begin
      failures++;
      $display("FAIL idle_done valid=%b prod=%h q=%b err=%b exp=0/0000/000/0", valid, prod, q, err);
    end
  endtask

  task automatic test_done_with_ctrl();
    load(8'd23, 8'd45);
    run_steps(8'd45, "done_ctrl");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (prod !== ref_mul(8'd23, 8'd45) || valid !== 1'b1) begin
      failures++;
      $display("FAIL done_ctrl got=%h/%b exp=%h/1", prod, valid, ref_mul(8'd23, 8'd45));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    logic [N-1:0] x;
    for (int t = 0; t < 24; t++) begin
      m = N'($urandom);
      x = N'($urandom);
      if (t == 0) begin m = 8'h80; x = 8'h7F; end
      if (t == 1) begin m = 8'h7F; x = 8'h80; end
      if (t == 2) begin m = 8'h00; x = 8'hFF; end
      do_op(m, x, "rand");
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; add = 1'b0; sub = 1'b0; sh = 1'b0; done = 1'b0;
    mcand = '0; mplier = '0;
    test_reset();
    test_directed();
    test_q_shift();
    test_error();
    test_reset_mid();
    test_hold_idle();
    test_done_with_ctrl();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
